// File: rtl/aes_ctr_stream_if.sv
// aes_ctr_stream_if: start/config, input stream and output stream of the AES-256 CTR engine
interface aes_ctr_stream_if #(
   parameter int CNT_W = 16
);
   logic             start;
   logic [255:0]     key;
   logic [127:0]     iv;
   logic [CNT_W-1:0] num_blocks;
   logic             in_valid;
   logic             in_ready;
   logic [127:0]     in_data;
   logic             out_valid;
   logic             out_ready;
   logic [127:0]     out_data;
   logic             out_last;
   logic             busy;
   logic             done;

   modport master (
      output start, key, iv, num_blocks, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last, busy, done
   );

   modport slave (
      input  start, key, iv, num_blocks, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last, busy, done
   );
endinterface

// File: rtl/aes_ctr_stream.sv
// aes_ctr_stream: AES-256 counter-mode stream engine; in_data ^ AES(key, ctr) through a stalling pipeline.
// The same datapath encrypts and decrypts.
module aes_ctr_stream #(
   parameter int CTR_BITS    = 32,
   parameter int PIPE_STAGES = 1,
   parameter int CNT_W       = 16
) (
   input logic clk,
   input logic rst_n,
   aes_ctr_stream_if.slave bus
);
   localparam logic [127:0] CTR_MASK = (CTR_BITS >= 128) ? '1 : (128'd1 << CTR_BITS) - 128'd1;

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         p = b[i] ? p ^ x : p;
         x = xt(x);
      end
      return p;
   endfunction

   // S-box as GF(2^8) inverse (a^254) followed by the affine map
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] s, r;
      s = a;
      r = 8'h01;
      for (int i = 1; i < 8; i++) begin
         s = gmul(s, s);
         r = gmul(r, s);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [127:0] sub_shift(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127 - 8 * (4 * c + r) -: 8] = sbox(s[127 - 8 * (4 * ((c + r) % 4) + r) -: 8]);
      return o;
   endfunction

   function automatic logic [31:0] mix(input logic [31:0] w);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = w;
      return {xt(a0 ^ a1) ^ a1 ^ a2 ^ a3, xt(a1 ^ a2) ^ a2 ^ a3 ^ a0,
              xt(a2 ^ a3) ^ a3 ^ a0 ^ a1, xt(a3 ^ a0) ^ a0 ^ a1 ^ a2};
   endfunction

   function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [255:0] k);
      logic [59:0][31:0] w;
      logic [31:0] t;
      logic [7:0] rc;
      logic [127:0] s;
      rc = 8'h01;
      w = '0;
      for (int i = 0; i < 60; i++) begin
         if (i < 8) w[i] = k[255 - 32 * i -: 32];
         else begin
            t = w[i - 1];
            if (i % 8 == 0) begin
               t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
               rc = xt(rc);
            end else if (i % 8 == 4) t = sub_word(t);
            w[i] = w[i - 8] ^ t;
         end
      end
      s = pt ^ {w[0], w[1], w[2], w[3]};
      for (int r = 1; r < 14; r++) begin
         s = sub_shift(s);
         s = {mix(s[127:96]), mix(s[95:64]), mix(s[63:32]), mix(s[31:0])}
             ^ {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
      end
      return sub_shift(s) ^ {w[56], w[57], w[58], w[59]};
   endfunction

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                       state, state_n;
   logic [255:0]                 key_r;
   logic [127:0]                 ctr_r, ks;
   logic [CNT_W-1:0]             issue_cnt, out_cnt;
   logic [PIPE_STAGES-1:0]       pv, pl;
   logic [PIPE_STAGES-1:0][127:0] pd;
   logic                         done_r, done_n, in_rdy, adv, acc, out_hs, ld, fin, last_in;

   assign ks      = aes_encrypt(ctr_r, key_r);
   assign adv     = !pv[PIPE_STAGES-1] | bus.out_ready;
   assign acc     = bus.in_valid & in_rdy;
   assign out_hs  = pv[PIPE_STAGES-1] & bus.out_ready;
   assign ld      = (state == IDLE) & bus.start & (bus.num_blocks != '0);
   assign fin     = (state == DRAIN) & out_hs & pl[PIPE_STAGES-1];
   assign last_in = issue_cnt == CNT_W'(1);

   assign bus.in_ready  = in_rdy;
   assign bus.out_valid = pv[PIPE_STAGES-1];
   assign bus.out_data  = pd[PIPE_STAGES-1];
   assign bus.out_last  = pl[PIPE_STAGES-1];
   assign bus.busy      = state != IDLE;
   assign bus.done      = done_r;

   always_comb begin
      state_n = state;
      in_rdy  = (state == RUN) & (issue_cnt != '0) & adv;
      done_n  = ((state == IDLE) & bus.start & (bus.num_blocks == '0)) | fin;
      if (ld) state_n = RUN;
      else if ((state == RUN) & bus.in_valid & in_rdy & last_in) state_n = DRAIN;
      else if (fin) state_n = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_r     <= '0;
         ctr_r     <= '0;
         issue_cnt <= '0;
         out_cnt   <= '0;
         done_r    <= 1'b0;
      end else begin
         done_r <= done_n;
         if (ld) begin
            key_r     <= bus.key;
            ctr_r     <= bus.iv;
            issue_cnt <= bus.num_blocks;
            out_cnt   <= bus.num_blocks;
         end else begin
            if (acc) begin
               ctr_r     <= (ctr_r & ~CTR_MASK) | ((ctr_r + 128'd1) & CTR_MASK);
               issue_cnt <= issue_cnt - CNT_W'(1);
            end
            if (out_hs) out_cnt <= out_cnt - CNT_W'(1);
         end
      end
   end

   // whole pipe advances together; bubbles carry valid=0 and last=0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pv <= '0;
         pl <= '0;
         pd <= '0;
      end else if (adv) begin
         for (int i = 1; i < PIPE_STAGES; i++) begin
            pv[i] <= pv[i - 1];
            pl[i] <= pl[i - 1];
            pd[i] <= pd[i - 1];
         end
         pv[0] <= acc;
         pl[0] <= acc & last_in;
         if (acc) pd[0] <= bus.in_data ^ ks;
      end
   end
endmodule

// File: tb/tb_aes_ctr_stream.sv
// tb_aes_ctr_stream: directed checks of the CTR engine against FIPS-197 constants and a table-driven AES-256 model
`timescale 1ns/1ps
module tb_aes_ctr_stream;
   localparam int P = 3;
   localparam logic [255:0] KEY0 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] IV0  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] KAT  = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int errors = 0;
   logic [127:0] din[$], dout[$], pt[$];
   logic lastq[$];
   logic [255:0] kr;
   logic [127:0] ivr;

   aes_ctr_stream_if #(.CNT_W(16)) bus ();
   aes_ctr_stream #(.CTR_BITS(32), .PIPE_STAGES(P), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic logic [7:0] sb(input logic [7:0] x);
      return SBOX[2047 - 8 * int'(x) -: 8];
   endfunction

   function automatic logic [7:0] mul2(input logic [7:0] x);
      return x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
   endfunction

   function automatic logic [127:0] ref_aes(input logic [127:0] p, input logic [255:0] k);
      logic [7:0] rk [240];
      logic [7:0] st [16];
      logic [7:0] t [16];
      logic [7:0] tmp [4];
      logic [7:0] a [4];
      logic [7:0] rc, x;
      logic [127:0] o;
      rc = 8'h01;
      for (int i = 0; i < 32; i++) rk[i] = k[255 - 8 * i -: 8];
      for (int i = 32; i < 240; i += 4) begin
         for (int j = 0; j < 4; j++) tmp[j] = rk[i - 4 + j];
         if (i % 32 == 0) begin
            x = tmp[0];
            tmp[0] = sb(tmp[1]) ^ rc;
            tmp[1] = sb(tmp[2]);
            tmp[2] = sb(tmp[3]);
            tmp[3] = sb(x);
            rc = mul2(rc);
         end else if (i % 32 == 16)
            for (int j = 0; j < 4; j++) tmp[j] = sb(tmp[j]);
         for (int j = 0; j < 4; j++) rk[i + j] = rk[i - 32 + j] ^ tmp[j];
      end
      for (int i = 0; i < 16; i++) st[i] = p[127 - 8 * i -: 8] ^ rk[i];
      for (int r = 1; r <= 14; r++) begin
         for (int i = 0; i < 16; i++) t[i] = sb(st[(i + 4 * (i % 4)) % 16]);
         if (r < 14)
            for (int c = 0; c < 4; c++) begin
               for (int j = 0; j < 4; j++) a[j] = t[4 * c + j];
               for (int j = 0; j < 4; j++)
                  t[4 * c + j] = mul2(a[j]) ^ mul2(a[(j + 1) % 4]) ^ a[(j + 1) % 4] ^ a[(j + 2) % 4] ^ a[(j + 3) % 4];
            end
         for (int i = 0; i < 16; i++) st[i] = t[i] ^ rk[16 * r + i];
      end
      for (int i = 0; i < 16; i++) o[127 - 8 * i -: 8] = st[i];
      return o;
   endfunction

   function automatic logic [127:0] ctr_at(input logic [127:0] v, input int i);
      return {v[127:32], v[31:0] + 32'(i)};
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic run_msg(input logic [255:0] k, input logic [127:0] v, input int n,
                          input int gap, input int stall, input bit spur);
      int sent = 0;
      int cyc = 0;
      bit fin = 0;
      bit hold = 0;
      bit ok = 0;
      logic [127:0] hd = '0;
      dout.delete();
      lastq.delete();
      @(posedge clk); #1;
      bus.key = k;
      bus.iv = v;
      bus.num_blocks = 16'(n);
      bus.start = 1'b1;
      while (cyc < 2000 && !ok) begin
         @(posedge clk); #1;
         bus.start = spur && cyc == 0;
         if (spur && cyc == 0) begin
            bus.key = ~k;
            bus.iv = ~v;
            bus.num_blocks = 16'(n + 3);
         end
         if (cyc == 0) chk("busy_after_start", bus.busy, 1);
         if (fin) begin
            chk("done_pulse", bus.done, 1);
            chk("busy_clear", bus.busy, 0);
            ok = 1;
         end else begin
            if (hold) begin
               chk("stall_valid", bus.out_valid, 1);
               chk("stall_data", bus.out_data, hd);
            end
            bus.in_valid = sent < n && $urandom_range(99) >= gap;
            bus.in_data = sent < n ? din[sent] : '0;
            bus.out_ready = $urandom_range(99) >= stall;
            #1;
            if (bus.out_valid && !bus.out_ready) chk("stall_in_ready", bus.in_ready, 0);
            if (bus.in_valid && bus.in_ready) sent++;
            hold = bus.out_valid && !bus.out_ready;
            hd = bus.out_data;
            if (bus.out_valid && bus.out_ready) begin
               dout.push_back(bus.out_data);
               lastq.push_back(bus.out_last);
               fin = bus.out_last;
            end
         end
         cyc++;
      end
      bus.in_valid = 1'b0;
      bus.start = 1'b0;
      bus.out_ready = 1'b1;
      chk("msg_complete", ok, 1);
   endtask

   task automatic check_msg(input logic [255:0] k, input logic [127:0] v, input int n);
      chk("out_count", dout.size(), n);
      for (int i = 0; i < n && i < dout.size(); i++) begin
         chk($sformatf("out_data[%0d]", i), dout[i], din[i] ^ ref_aes(ctr_at(v, i), k));
         chk($sformatf("out_last[%0d]", i), lastq[i], i == n - 1);
      end
   endtask

   initial begin
      bus.start = 1'b0;
      bus.key = '0;
      bus.iv = '0;
      bus.num_blocks = '0;
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      bus.out_ready = 1'b0;
      #12;
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_out_last", bus.out_last, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      @(negedge clk) rst_n = 1'b1;

      // known answer with latency
      @(posedge clk); #1;
      bus.key = KEY0;
      bus.iv = IV0;
      bus.num_blocks = 16'd1;
      bus.start = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data = '0;
      #1;
      chk("kat_busy", bus.busy, 1);
      chk("kat_in_ready", bus.in_ready, 1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      #1;
      chk("kat_drain_in_ready", bus.in_ready, 0);
      for (int i = 0; i < P - 1; i++) begin
         chk($sformatf("kat_latency_%0d", i), bus.out_valid, 0);
         @(posedge clk); #1;
      end
      chk("kat_out_valid", bus.out_valid, 1);
      chk("kat_out_data", bus.out_data, KAT);
      chk("kat_out_last", bus.out_last, 1);
      chk("kat_done_early", bus.done, 0);
      @(posedge clk); #1;
      chk("kat_done", bus.done, 1);
      chk("kat_busy_drop", bus.busy, 0);
      chk("kat_out_valid_clear", bus.out_valid, 0);
      @(posedge clk); #1;
      chk("kat_done_single", bus.done, 0);

      // multi-block increment
      din = '{128'h0, 128'h0, 128'h0};
      run_msg(KEY0, IV0, 3, 0, 0, 0);
      check_msg(KEY0, IV0, 3);
      chk("inc_blk0", dout[0], KAT);
      chk("inc_blk1", dout[1], ref_aes(128'h00112233445566778899aabbccddef00, KEY0));
      chk("inc_blk2", dout[2], ref_aes(128'h00112233445566778899aabbccddef01, KEY0));

      // low 32-bit counter wrap
      din = '{128'h0, 128'h0};
      run_msg(KEY0, 128'h0123456789abcdef01234567ffffffff, 2, 0, 0, 0);
      chk("wrap_blk0", dout[0], ref_aes(128'h0123456789abcdef01234567ffffffff, KEY0));
      chk("wrap_blk1", dout[1], ref_aes(128'h0123456789abcdef0123456700000000, KEY0));
      chk("wrap_last", lastq[1], 1);

      // start while busy is ignored
      din = '{128'h1, 128'h2};
      run_msg(KEY0, IV0, 2, 0, 0, 1);
      check_msg(KEY0, IV0, 2);

      // round trip
      kr = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      ivr = {$urandom, $urandom, $urandom, 32'hfffffffd};
      din.delete();
      for (int i = 0; i < 8; i++) din.push_back({$urandom, $urandom, $urandom, $urandom});
      pt = din;
      run_msg(kr, ivr, 8, 20, 20, 0);
      check_msg(kr, ivr, 8);
      din = dout;
      run_msg(kr, ivr, 8, 20, 20, 0);
      chk("rt_count", dout.size(), 8);
      for (int i = 0; i < 8 && i < dout.size(); i++) chk($sformatf("roundtrip[%0d]", i), dout[i], pt[i]);

      // backpressure, input gaps and a spurious start
      ivr = {$urandom, $urandom, $urandom, $urandom};
      din.delete();
      for (int i = 0; i < 20; i++) din.push_back({$urandom, $urandom, $urandom, $urandom});
      run_msg(~KEY0, ivr, 20, 30, 40, 1);
      check_msg(~KEY0, ivr, 20);

      // zero-length message
      @(posedge clk); #1;
      bus.num_blocks = '0;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk("zero_done", bus.done, 1);
      chk("zero_busy", bus.busy, 0);
      chk("zero_out_valid", bus.out_valid, 0);
      @(posedge clk); #1;
      chk("zero_done_single", bus.done, 0);
      chk("zero_busy_after", bus.busy, 0);

      // reset mid-message
      @(posedge clk); #1;
      bus.key = KEY0;
      bus.iv = IV0;
      bus.num_blocks = 16'd4;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data = {$urandom, $urandom, $urandom, $urandom};
      bus.out_ready = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      chk("mid_out_valid", bus.out_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", bus.out_valid, 0);
      chk("mid_rst_out_data", bus.out_data, 0);
      chk("mid_rst_out_last", bus.out_last, 0);
      chk("mid_rst_busy", bus.busy, 0);
      chk("mid_rst_in_ready", bus.in_ready, 0);
      chk("mid_rst_done", bus.done, 0);
      bus.out_ready = 1'b1;
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("mid_no_done", bus.done, 0);
      din = '{128'h0};
      run_msg(KEY0, IV0, 1, 0, 0, 0);
      chk("post_rst_count", dout.size(), 1);
      chk("post_rst_kat", dout[0], KAT);
      chk("post_rst_last", lastq[0], 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
